// File: rtl/mmio_console_rx_pkg.sv
// Shared console MMIO definitions: data-bus request/response types, console
// TX/halt/RX addresses and RX STATUS register bit positions.
package mmio_console_rx_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
  } memory_io_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } memory_io_rsp;

  localparam logic [31:0] console_tx_addr        = 32'h0002_FFF8;
  localparam logic [31:0] halt_addr              = 32'h0002_FFFD;
  localparam logic [31:0] console_rx_data_addr   = 32'h0002_FFF0;
  localparam logic [31:0] console_rx_status_addr = console_rx_data_addr + 32'd4;

  localparam int status_nonempty_bit = 0;
  localparam int status_full_bit     = 1;
  localparam int status_overflow_bit = 2;
  localparam int status_count_lsb    = 8;

  localparam logic [31:0] rx_eof_word = 32'hFFFF_FFFF;

  function automatic logic [31:0] status_word(input logic nonempty, input logic full,
                                              input logic overflow, input logic [7:0] count);
    logic [31:0] s;
    s = '0;
    s[status_nonempty_bit]       = nonempty;
    s[status_full_bit]           = full;
    s[status_overflow_bit]       = overflow;
    s[status_count_lsb +: 8]     = count;
    return s;
  endfunction

endpackage

// File: rtl/mmio_console_rx_byte_fifo.sv
// Circular byte FIFO with push/pop/flush and occupancy count; flush overrides
// push and pop in the same cycle.
module mmio_console_rx_byte_fifo #(
  parameter int depth = 16,
  parameter int width = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [width-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [width-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth):0]     count,
  output logic [$clog2(depth):0]     count_next
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == cw'(depth));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (flush)
      count_next = '0;
    else if (push_ok && !pop_ok)
      count_next = count + cw'(1);
    else if (pop_ok && !push_ok)
      count_next = count - cw'(1);
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + aw'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + aw'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmio_console_rx.sv
// Memory-mapped console input: host bytes stream into a FIFO, the core pops
// them via RX_DATA loads and inspects/controls the buffer via STATUS.
module mmio_console_rx
  import mmio_console_rx_pkg::*;
#(
  parameter int          depth     = 16,
  parameter logic [31:0] base_addr = console_rx_data_addr
) (
  input  logic         clk,
  input  logic         reset,
  input  memory_io_req req,
  output memory_io_rsp rsp,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         irq
);

  localparam logic [31:0] status_addr = base_addr + 32'd4;
  localparam int          cw          = $clog2(depth) + 1;

  logic          hit_data, hit_status, rd, pop, flush, ovf_clr, ovf_set;
  logic          overflow, full, empty;
  logic [7:0]    head;
  logic [cw-1:0] count, count_next;
  logic [31:0]   rd_data;
  logic          unused_req_bits;

  assign hit_data   = req.valid && (req.addr == base_addr);
  assign hit_status = req.valid && (req.addr == status_addr);
  assign rd         = |req.do_read;
  assign pop        = hit_data && rd;
  assign flush      = hit_status && req.do_write[0] && req.data[0];
  assign ovf_clr    = hit_status && req.do_write[0] && req.data[2];
  // A byte offered while full is lost unless a flush discards it anyway.
  assign ovf_set    = in_valid && full && !flush;
  assign in_ready   = !full;

  mmio_console_rx_byte_fifo #(.depth(depth), .width(8)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .wdata     (in_data),
    .pop       (pop),
    .flush     (flush),
    .rdata     (head),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .count_next(count_next)
  );

  always_comb begin
    rd_data = '0;
    if (hit_data)
      rd_data = empty ? rx_eof_word : {24'h0, head};
    else
      rd_data = status_word(!empty, full, overflow, 8'(count));
  end

  always_ff @(posedge clk) begin
    if (reset)
      overflow <= 1'b0;
    else if (ovf_set)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp.valid <= 1'b0;
      rsp.addr  <= '0;
      rsp.data  <= '0;
      irq       <= 1'b0;
    end else begin
      rsp.valid <= (hit_data || hit_status) && rd;
      if ((hit_data || hit_status) && rd) begin
        rsp.addr <= req.addr;
        rsp.data <= rd_data;
      end
      irq <= (count_next != '0);
    end
  end

  assign unused_req_bits = ^{req.do_write[3:1], req.data[31:3], req.data[1]};

endmodule

// File: tb/tb_mmio_console_rx.sv
// Self-checking bench for mmio_console_rx: directed scenarios plus a randomized
// run against a queue-based model of the console RX device.
module tb_mmio_console_rx;
  import mmio_console_rx_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  memory_io_req req;
  memory_io_rsp rsp;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         irq;

  int checks = 0;
  int errors = 0;

  logic [7:0]  q[$];
  logic        m_ovf;
  logic        exp_valid;
  logic [31:0] exp_data, exp_addr;

  always #5 clk = ~clk;

  mmio_console_rx dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .rsp     (rsp),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .irq     (irq)
  );

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[0] = (q.size() != 0);
    s[1] = (q.size() == 16);
    s[2] = m_ovf;
    s[15:8] = 8'(q.size());
    return s;
  endfunction

  task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] r, input logic [3:0] w);
    req.valid = v; req.addr = a; req.data = d; req.do_read = r; req.do_write = w;
  endtask

  task automatic idle_req();
    set_req(1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
  endtask

  // Advance the model by one clock edge from the currently driven inputs, then tick.
  task automatic step();
    logic rd_d, rd_s, flush, full_b, clr;
    full_b = (q.size() == 16);
    rd_d   = req.valid && req.addr == console_rx_data_addr && req.do_read != 0;
    rd_s   = req.valid && req.addr == console_rx_status_addr && req.do_read != 0;
    flush  = req.valid && req.addr == console_rx_status_addr && req.do_write[0] && req.data[0];
    clr    = req.valid && req.addr == console_rx_status_addr && req.do_write[0] && req.data[2];
    if (reset) begin
      q.delete(); m_ovf = 1'b0; exp_valid = 1'b0; exp_data = '0; exp_addr = '0;
    end else begin
      exp_valid = rd_d || rd_s;
      if (rd_d) begin
        exp_addr = req.addr;
        exp_data = (q.size() != 0) ? {24'h0, q[0]} : 32'hFFFF_FFFF;
      end else if (rd_s) begin
        exp_addr = req.addr;
        exp_data = model_status();
      end
      if (flush) begin
        q.delete();
        if (clr) m_ovf = 1'b0;
      end else begin
        if (rd_d && q.size() != 0) void'(q.pop_front());
        if (in_valid && !full_b) q.push_back(in_data);
        if (in_valid && full_b) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h0; idle_req();
    step(); step();
    checks++;
    if (rsp !== '0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rsp=%h irq=%b required rsp=0 irq=0", rsp, irq);
    end
    reset = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    set_req(1'b1, console_rx_status_addr, 32'h0, 4'hF, 4'h0);
    step();
    idle_req();
    checks++;
    if (rsp.valid !== 1'b1 || rsp.data !== 32'h0 || rsp.addr !== console_rx_status_addr || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_status_read: valid=%b data=%h addr=%h irq=%b required 1/00000000/%h/0",
               rsp.valid, rsp.data, rsp.addr, irq, console_rx_status_addr);
    end
    step();
    checks++;
    if (rsp.valid !== 1'b0) begin
      errors++; $display("FAIL rsp_single_cycle: valid=%b required 0", rsp.valid);
    end
  endtask

  task automatic test_hi();
    logic [31:0] exp_st [3] = '{32'h0000_0201, 32'h0000_0101, 32'h0000_0000};
    logic [31:0] exp_rd [3] = '{32'h0000_0048, 32'h0000_0069, 32'hFFFF_FFFF};
    in_valid = 1'b1; in_data = 8'h48; step();
    in_data = 8'h69; step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, console_rx_status_addr, 32'h0, 4'hF, 4'h0);
      step();
      checks++;
      if (rsp.valid !== 1'b1 || rsp.data !== exp_st[i]) begin
        errors++; $display("FAIL hi_status[%0d]: valid=%b data=%h required 1/%h", i, rsp.valid, rsp.data, exp_st[i]);
      end
      set_req(1'b1, console_rx_data_addr, 32'h0, 4'hF, 4'h0);
      step();
      checks++;
      if (rsp.valid !== 1'b1 || rsp.data !== exp_rd[i] || rsp.addr !== console_rx_data_addr) begin
        errors++; $display("FAIL hi_data[%0d]: valid=%b data=%h addr=%h required 1/%h", i, rsp.valid, rsp.data, rsp.addr, exp_rd[i]);
      end
    end
    idle_req();
    step();
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL hi_irq_empty: got %b required 0", irq);
    end
  endtask

  task automatic test_overflow();
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(8'h10 + i);
      step();
      if (i == 14 || i == 15) begin
        checks++;
        if (in_ready !== (i == 14)) begin
          errors++; $display("FAIL ovf_in_ready_after_%0d: got %b required %b", i + 1, in_ready, (i == 14));
        end
      end
    end
    in_valid = 1'b0;
    set_req(1'b1, console_rx_status_addr, 32'h0, 4'hF, 4'h0);
    step();
    checks++;
    if (rsp.data !== 32'h0000_1007 || irq !== 1'b1) begin
      errors++; $display("FAIL ovf_status: data=%h irq=%b required 00001007/1", rsp.data, irq);
    end
    // Full FIFO: push and RX_DATA read in the same cycle; the push is refused.
    in_valid = 1'b1; in_data = 8'hAA;
    set_req(1'b1, console_rx_data_addr, 32'h0, 4'hF, 4'h0);
    step();
    in_valid = 1'b0;
    checks++;
    if (rsp.data !== 32'h0000_0010) begin
      errors++; $display("FAIL full_pushpop_data: got %h required 00000010", rsp.data);
    end
    set_req(1'b1, console_rx_status_addr, 32'h0, 4'hF, 4'h0);
    step();
    checks++;
    if (rsp.data !== 32'h0000_0F05 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_pushpop_status: data=%h in_ready=%b required 00000F05/1", rsp.data, in_ready);
    end
  endtask

  task automatic test_flush_clear();
    set_req(1'b1, console_rx_status_addr, 32'h5, 4'h0, 4'hF);
    step();
    checks++;
    if (rsp.valid !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL flush_write: valid=%b irq=%b required 0/0", rsp.valid, irq);
    end
    set_req(1'b1, console_rx_status_addr, 32'h0, 4'hF, 4'h0);
    step();
    checks++;
    if (rsp.data !== 32'h0) begin
      errors++; $display("FAIL flush_status: got %h required 00000000", rsp.data);
    end
    set_req(1'b1, console_tx_addr, 32'h41, 4'h0, 4'hF);
    step();
    checks++;
    if (rsp.valid !== 1'b0) begin
      errors++; $display("FAIL foreign_write_rsp: valid=%b required 0", rsp.valid);
    end
    set_req(1'b1, halt_addr, 32'h0, 4'hF, 4'h0);
    step();
    checks++;
    if (rsp.valid !== 1'b0) begin
      errors++; $display("FAIL foreign_read_rsp: valid=%b required 0", rsp.valid);
    end
    idle_req();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_data = 8'(8'h30 + i); step(); end
    in_valid = 1'b0;
    set_req(1'b1, console_rx_data_addr, 32'h0, 4'hF, 4'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_req();
    checks++;
    if (rsp.valid !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_mid_rsp: valid=%b irq=%b required 0/0", rsp.valid, irq);
    end
    set_req(1'b1, console_rx_status_addr, 32'h0, 4'hF, 4'h0);
    step();
    idle_req();
    checks++;
    if (rsp.valid !== 1'b1 || rsp.data !== 32'h0) begin
      errors++; $display("FAIL reset_mid_status: valid=%b data=%h required 1/00000000", rsp.valid, rsp.data);
    end
  endtask

  task automatic test_random();
    int sel;
    for (int n = 0; n < 600; n++) begin
      in_valid = ($urandom_range(0, 9) < 6);
      in_data  = 8'($urandom);
      sel = $urandom_range(0, 19);
      if (sel < 5)       set_req(1'b1, console_rx_data_addr, $urandom, 4'($urandom_range(1, 15)), 4'h0);
      else if (sel < 8)  set_req(1'b1, console_rx_status_addr, $urandom, 4'hF, 4'h0);
      else if (sel == 8) set_req(1'b1, console_rx_status_addr, $urandom, 4'h0, 4'($urandom));
      else if (sel == 9) set_req(1'b1, (n % 2) ? console_tx_addr : halt_addr, $urandom, 4'($urandom), 4'($urandom));
      else if (sel == 10) set_req(1'b0, console_rx_data_addr, 32'h0, 4'hF, 4'h0);
      else               idle_req();
      step();
      checks++;
      if (rsp.valid !== exp_valid || (exp_valid && (rsp.data !== exp_data || rsp.addr !== exp_addr))) begin
        errors++;
        $display("FAIL rand_rsp[%0d]: valid=%b data=%h addr=%h required %b/%h/%h",
                 n, rsp.valid, rsp.data, rsp.addr, exp_valid, exp_data, exp_addr);
      end
      checks++;
      if (irq !== (q.size() != 0) || in_ready !== (q.size() != 16)) begin
        errors++;
        $display("FAIL rand_flags[%0d]: irq=%b in_ready=%b required %b/%b",
                 n, irq, in_ready, (q.size() != 0), (q.size() != 16));
      end
    end
    in_valid = 1'b0;
    idle_req();
  endtask

  initial begin
    test_reset();
    test_hi();
    test_overflow();
    test_flush_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
